// File: rtl/watch_cmd_arbiter_if.sv
// Command-path bundle between the button/UART front end and the watch command arbiter.
// The arbiter connects through the slave modport; the requesting side uses master.
interface watch_cmd_arbiter_if;
    logic [3:0] btn_cmd;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       mode_sw;
    logic       o_clear;
    logic       o_runstop;
    logic       o_up;
    logic       o_down;
    logic       o_busy;
    logic       o_fifo_full;
    logic       o_drop;

    modport master (
        output btn_cmd, rx_valid, rx_data, mode_sw,
        input  o_clear, o_runstop, o_up, o_down, o_busy, o_fifo_full, o_drop
    );

    modport slave (
        input  btn_cmd, rx_valid, rx_data, mode_sw,
        output o_clear, o_runstop, o_up, o_down, o_busy, o_fifo_full, o_drop
    );
endinterface

// File: rtl/watch_cmd_arbiter.sv
// Round-robin arbiter sharing the watch/stopwatch command path between front-panel buttons
// and UART command bytes, with a minimum pulse spacing and display-mode routing.
module watch_cmd_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    watch_cmd_arbiter_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 2);

    localparam logic SRC_BTN  = 1'b0;
    localparam logic SRC_UART = 1'b1;

    localparam logic [1:0] CMD_CLEAR   = 2'd0;
    localparam logic [1:0] CMD_RUNSTOP = 2'd1;
    localparam logic [1:0] CMD_UP      = 2'd2;
    localparam logic [1:0] CMD_DOWN    = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]    fifo_q [FIFO_DEPTH];
    logic [1:0]    fifo_d [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          slot_valid_q, slot_valid_d;
    logic [1:0]    slot_cmd_q, slot_cmd_d;
    logic          last_grant_q, last_grant_d;
    logic [3:0]    pulse_q, pulse_d;
    logic          drop_q, drop_d;

    logic          rx_hit;
    logic [1:0]    rx_cmd;
    logic          btn_any;
    logic          btn_multi;
    logic [1:0]    btn_sel;
    logic          grant_window;
    logic          grant;
    logic          pick_btn;
    logic [1:0]    grant_cmd;
    logic          mode_ok;
    logic          push;
    logic          pop;

    always_comb begin
        rx_hit = 1'b0;
        rx_cmd = CMD_CLEAR;
        if (bus.rx_valid) begin
            case (bus.rx_data)
                8'h43, 8'h63: begin rx_hit = 1'b1; rx_cmd = CMD_CLEAR;   end
                8'h52, 8'h72: begin rx_hit = 1'b1; rx_cmd = CMD_RUNSTOP; end
                8'h55, 8'h75: begin rx_hit = 1'b1; rx_cmd = CMD_UP;      end
                8'h44, 8'h64: begin rx_hit = 1'b1; rx_cmd = CMD_DOWN;    end
                default:      rx_hit = 1'b0;
            endcase
        end
    end

    assign btn_any   = |bus.btn_cmd;
    assign btn_multi = (bus.btn_cmd & (bus.btn_cmd - 4'd1)) != 4'd0;

    always_comb begin
        if (bus.btn_cmd[0])      btn_sel = CMD_CLEAR;
        else if (bus.btn_cmd[1]) btn_sel = CMD_RUNSTOP;
        else if (bus.btn_cmd[2]) btn_sel = CMD_UP;
        else                     btn_sel = CMD_DOWN;
    end

    // Buttons win a tie only when the UART held the previous grant.
    always_comb begin
        grant_window = (state_q == IDLE) || ((state_q == GAP) && (gap_cnt_q == '0));
        pick_btn     = slot_valid_q && ((count_q == '0) || (last_grant_q == SRC_UART));
        grant        = grant_window && (slot_valid_q || (count_q != '0));
        grant_cmd    = pick_btn ? slot_cmd_q : fifo_q[rd_ptr_q];
        mode_ok      = (grant_cmd[1] != bus.mode_sw);
    end

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        slot_valid_d = slot_valid_q;
        slot_cmd_d   = slot_cmd_q;
        last_grant_d = last_grant_q;
        pulse_d      = '0;
        drop_d       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;

        // A mode mismatch still consumes the request, it just reports a drop instead of a pulse.
        if (grant) begin
            last_grant_d = pick_btn ? SRC_BTN : SRC_UART;
            if (pick_btn) begin
                slot_valid_d = 1'b0;
            end else begin
                pop      = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (mode_ok) pulse_d[grant_cmd] = 1'b1;
            else         drop_d = 1'b1;
        end

        if (rx_hit) begin
            if ((count_q != FULL_COUNT) || pop) begin
                push             = 1'b1;
                fifo_d[wr_ptr_q] = rx_cmd;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (btn_any) begin
            if (!slot_valid_q || (grant && pick_btn)) begin
                slot_valid_d = 1'b1;
                slot_cmd_d   = btn_sel;
            end else begin
                drop_d = 1'b1;
            end
            if (btn_multi) drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (grant && mode_ok) state_d = ISSUE;
            end
            ISSUE: begin
                state_d   = GAP;
                gap_cnt_d = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt_q != '0)       gap_cnt_d = gap_cnt_q - 1'b1;
                else if (grant && mode_ok) state_d = ISSUE;
                else                       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= CMD_CLEAR;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            slot_valid_q <= 1'b0;
            slot_cmd_q   <= CMD_CLEAR;
            last_grant_q <= SRC_UART;
            pulse_q      <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            slot_valid_q <= slot_valid_d;
            slot_cmd_q   <= slot_cmd_d;
            last_grant_q <= last_grant_d;
            pulse_q      <= pulse_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.o_clear     = pulse_q[CMD_CLEAR];
    assign bus.o_runstop   = pulse_q[CMD_RUNSTOP];
    assign bus.o_up        = pulse_q[CMD_UP];
    assign bus.o_down      = pulse_q[CMD_DOWN];
    assign bus.o_busy      = (state_q != IDLE);
    assign bus.o_fifo_full = (count_q == FULL_COUNT);
    assign bus.o_drop      = drop_q;
endmodule

// File: tb/tb_watch_cmd_arbiter.sv
// Directed scoreboard bench for watch_cmd_arbiter: expected pulses and drops are queued
// with the clock edge they must appear on and retired by a negedge monitor.
module tb_watch_cmd_arbiter;
    localparam logic [3:0] P_CLEAR   = 4'b0001;
    localparam logic [3:0] P_RUNSTOP = 4'b0010;
    localparam logic [3:0] P_UP      = 4'b0100;
    localparam logic [3:0] P_DOWN    = 4'b1000;

    typedef struct {
        logic [3:0] pulse;
        int         at;
    } pulse_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    pulse_exp_t pulse_exp[$];
    int         drop_exp[$];

    watch_cmd_arbiter_if bus();

    watch_cmd_arbiter #(
        .GAP_CYCLES(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] p, input int at);
        pulse_exp_t item;
        item.pulse = p;
        item.at    = at;
        pulse_exp.push_back(item);
    endtask

    task automatic expect_drop(input int at);
        drop_exp.push_back(at);
    endtask

    // Called at a negedge; inputs are sampled on the following posedge (edge cyc+1).
    task automatic apply_stimulus(input logic [3:0] btn, input logic rx_v, input logic [7:0] rx_d);
        bus.btn_cmd  = btn;
        bus.rx_valid = rx_v;
        bus.rx_data  = rx_d;
        @(negedge clk);
        bus.btn_cmd  = 4'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic settle(input int n, input string tag);
        repeat (n) @(negedge clk);
        check_output({tag, "_pulses_left"}, 32'(pulse_exp.size()), 32'd0);
        check_output({tag, "_drops_left"}, 32'(drop_exp.size()), 32'd0);
        check_output({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check_output({tag, "_full"}, 32'(bus.o_fifo_full), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        logic [3:0] seen;
        pulse_exp_t item;
        int         at;
        seen = {bus.o_down, bus.o_up, bus.o_runstop, bus.o_clear};
        if (seen !== 4'b0) begin
            check_output("pulse_onehot", 32'($countones(seen)), 32'd1);
            if (pulse_exp.size() == 0) begin
                check_output("unexpected_pulse", 32'(seen), 32'd0);
            end else begin
                item = pulse_exp.pop_front();
                check_output("pulse_cmd", 32'(seen), 32'(item.pulse));
                check_output("pulse_cycle", cyc, item.at);
            end
        end
        if (bus.o_drop === 1'b1) begin
            if (drop_exp.size() == 0) begin
                check_output("unexpected_drop", 32'(bus.o_drop), 32'd0);
            end else begin
                at = drop_exp.pop_front();
                check_output("drop_cycle", cyc, at);
            end
        end
    end

    initial begin
        int e;
        reset        = 1'b0;
        bus.btn_cmd  = 4'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.mode_sw  = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_outputs",
                     32'({bus.o_clear, bus.o_runstop, bus.o_up, bus.o_down,
                          bus.o_busy, bus.o_fifo_full, bus.o_drop}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] button clear in stopwatch mode");
        e = cyc + 1;
        expect_pulse(P_CLEAR, e + 1);
        apply_stimulus(4'b0001, 1'b0, 8'h00);
        @(negedge clk);
        check_output("t1_busy_issue", 32'(bus.o_busy), 32'd1);
        settle(10, "t1");

        $display("[TB] UART up, ignored byte, mode mismatch");
        bus.mode_sw = 1'b0;
        e = cyc + 1;
        expect_pulse(P_UP, e + 1);
        apply_stimulus(4'b0000, 1'b1, 8'h75);
        settle(8, "t2a");
        apply_stimulus(4'b0000, 1'b1, 8'h78);
        settle(6, "t2b");
        bus.mode_sw = 1'b1;
        e = cyc + 1;
        expect_drop(e + 1);
        apply_stimulus(4'b0000, 1'b1, 8'h55);
        @(negedge clk);
        check_output("t2_mismatch_idle", 32'(bus.o_busy), 32'd0);
        settle(6, "t2c");

        $display("[TB] button/UART ties, round-robin");
        e = cyc + 1;
        expect_pulse(P_RUNSTOP, e + 1);
        expect_pulse(P_CLEAR, e + 5);
        expect_pulse(P_RUNSTOP, e + 9);
        expect_pulse(P_CLEAR, e + 13);
        apply_stimulus(4'b0010, 1'b1, 8'h43);
        @(negedge clk);
        apply_stimulus(4'b0010, 1'b1, 8'h43);
        settle(20, "t3");

        $display("[TB] UART burst overflows the queue");
        e = cyc + 1;
        for (int i = 0; i < 6; i++) expect_pulse(P_RUNSTOP, e + 1 + 4 * i);
        expect_drop(e + 6);
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1'b1, 8'h72);
        check_output("t4_not_full", 32'(bus.o_fifo_full), 32'd0);
        for (int i = 0; i < 4; i++) apply_stimulus(4'b0000, 1'b1, 8'h72);
        check_output("t4_full", 32'(bus.o_fifo_full), 32'd1);
        settle(30, "t4");

        $display("[TB] simultaneous buttons and occupied slot");
        e = cyc + 1;
        expect_drop(e);
        expect_pulse(P_CLEAR, e + 1);
        apply_stimulus(4'b0101, 1'b0, 8'h00);
        settle(8, "t5a");
        e = cyc + 1;
        expect_pulse(P_CLEAR, e + 1);
        expect_drop(e + 2);
        expect_pulse(P_RUNSTOP, e + 5);
        apply_stimulus(4'b0001, 1'b0, 8'h00);
        apply_stimulus(4'b0010, 1'b0, 8'h00);
        apply_stimulus(4'b0100, 1'b0, 8'h00);
        settle(12, "t5b");

        $display("[TB] reset during gap with queued commands");
        e = cyc + 1;
        expect_pulse(P_RUNSTOP, e + 1);
        for (int i = 0; i < 4; i++) apply_stimulus(4'b0000, 1'b1, 8'h72);
        check_output("t6_busy_before", 32'(bus.o_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_output("t6_outputs_in_reset",
                     32'({bus.o_clear, bus.o_runstop, bus.o_up, bus.o_down,
                          bus.o_busy, bus.o_fifo_full, bus.o_drop}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        settle(12, "t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
